// File: rtl/hbird_reset_pkg.sv
// Shared types and constants for the Hummingbird reset-request front end.
package hbird_reset_pkg;

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_LOCK = 1;
  localparam int CAUSE_BTN  = 2;
  localparam int CAUSE_SW   = 3;
  localparam int CAUSE_W    = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_RESET = 4'b0001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hbird_reset_debounce.sv
// Multi-flop synchroniser with an optional debounce filter; DEBOUNCE_BITS=0
// gives a plain synchroniser.
module hbird_reset_debounce #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   DEBOUNCE_BITS = 16,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_BITS == 0) begin : g_bypass
      assign dout = synced;
    end else begin : g_filter
      localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = DEBOUNCE_BITS'(1);

      logic [DEBOUNCE_BITS-1:0] cnt_q;
      logic                     db_q;

      // The output flips only after the input has differed for a full
      // 2^DEBOUNCE_BITS consecutive cycles; any agreement restarts the count.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
          db_q  <= RESET_VALUE;
        end else if (synced == db_q) begin
          cnt_q <= '0;
        end else if (&cnt_q) begin
          cnt_q <= '0;
          db_q  <= synced;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end

      assign dout = db_q;
    end
  endgenerate

endmodule

// File: rtl/hbird_reset_ctrl.sv
// Merges POR, push-button, MMCM lock loss and software reset requests into a
// glitch-free registered areset, drives the MMCM reset and records the cause.
module hbird_reset_ctrl
  import hbird_reset_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_BITS     = 16,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int LOCK_HOLD_CYCLES  = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  output logic       mmcm_reset,
  output logic       areset,
  output logic [3:0] cause,
  output logic [1:0] fsm_state
);

  localparam int CNT_MAX = max_int(MIN_ASSERT_CYCLES, LOCK_HOLD_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(LOCK_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic btn_db;
  logic locked_s;
  logic sw_s;
  logic evt;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CAUSE_W-1:0] evt_cause;
  logic               areset_q;
  logic               mmcm_reset_q;

  hbird_reset_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_BITS(DEBOUNCE_BITS),
    .RESET_VALUE  (1'b1)
  ) u_btn (
    .clock  (clock),
    .reset_n(reset_n),
    .din    (btn_n),
    .dout   (btn_db)
  );

  hbird_reset_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_BITS(0),
    .RESET_VALUE  (1'b0)
  ) u_lock (
    .clock  (clock),
    .reset_n(reset_n),
    .din    (pll_locked),
    .dout   (locked_s)
  );

  hbird_reset_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_BITS(0),
    .RESET_VALUE  (1'b0)
  ) u_sw (
    .clock  (clock),
    .reset_n(reset_n),
    .din    (sw_rst_req),
    .dout   (sw_s)
  );

  // btn_db is the debounced active-low level, so a press reads as 0.
  assign evt = !btn_db || sw_s || !locked_s;

  always_comb begin
    evt_cause            = '0;
    evt_cause[CAUSE_SW]  = sw_s;
    evt_cause[CAUSE_BTN] = !btn_db;
    evt_cause[CAUSE_LOCK] = !locked_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    cause_d = cause_q;
    case (state_q)
      ASSERT: begin
        if (cnt_q == ASSERT_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        cnt_d = '0;
        if (!evt) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (evt) begin
          state_d = ASSERT;
          cnt_d   = '0;
          cause_d = evt_cause;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (evt) begin
          state_d = ASSERT;
          cause_d = evt_cause;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change only on edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ASSERT;
      cnt_q        <= '0;
      cause_q      <= CAUSE_RESET;
      areset_q     <= 1'b1;
      mmcm_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      areset_q     <= (state_d != RUN);
      mmcm_reset_q <= (state_d == ASSERT);
    end
  end

  assign areset     = areset_q;
  assign mmcm_reset = mmcm_reset_q;
  assign cause      = cause_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_hbird_reset_ctrl.sv
// Bench for hbird_reset_ctrl: directed latency checks plus randomized request
// traffic scored cycle by cycle against a phase/deadline reference model.
module tb_hbird_reset_ctrl;

  localparam int SYNC   = 2;
  localparam int DBB    = 3;
  localparam int MIN_AS = 4;
  localparam int HOLD_C = 16;

  localparam int P_ASSERT = 0;
  localparam int P_WAIT   = 1;
  localparam int P_HOLD   = 2;
  localparam int P_RUN    = 3;

  localparam logic [5:0] RESET_EXP = 6'b11_0001;

  logic       clock      = 1'b0;
  logic       reset_n    = 1'b0;
  logic       btn_n      = 1'b1;
  logic       pll_locked = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       mmcm_reset;
  logic       areset;
  logic [3:0] cause;
  logic [1:0] fsm_state;

  int vectors    = 0;
  int miscompares = 0;

  logic [5:0] exp_q[$];

  hbird_reset_ctrl #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_BITS    (DBB),
    .MIN_ASSERT_CYCLES(MIN_AS),
    .LOCK_HOLD_CYCLES (HOLD_C)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_n     (btn_n),
    .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req),
    .mmcm_reset(mmcm_reset),
    .areset    (areset),
    .cause     (cause),
    .fsm_state (fsm_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pins delayed through queues, button filtered by run
  // length, phases timed by the edge number at which they were entered.
  bit         q_btn[$], q_lock[$], q_sw[$];
  bit         m_db;
  int         m_run;
  int         m_phase;
  int         m_n, m_t;
  logic [3:0] m_cause;

  always @(posedge clock or negedge reset_n) begin : model
    bit b_s, l_s, s_s, evt;
    if (!reset_n) begin
      q_btn = '{1'b1, 1'b1};
      q_lock = '{1'b0, 1'b0};
      q_sw = '{1'b0, 1'b0};
      m_db = 1'b1;
      m_run = 0;
      m_phase = P_ASSERT;
      m_n = 0;
      m_t = 0;
      m_cause = 4'b0001;
      exp_q.delete();
      exp_q.push_back(RESET_EXP);
    end else begin
      b_s = q_btn.pop_front();  q_btn.push_back(btn_n);
      l_s = q_lock.pop_front(); q_lock.push_back(pll_locked);
      s_s = q_sw.pop_front();   q_sw.push_back(sw_rst_req);
      evt = !m_db || s_s || !l_s;
      m_n++;
      case (m_phase)
        P_ASSERT: if (m_n - m_t == MIN_AS) m_phase = P_WAIT;
        P_WAIT:   if (!evt) begin m_phase = P_HOLD; m_t = m_n; end
        P_HOLD, P_RUN: begin
          if (evt) begin
            m_phase = P_ASSERT;
            m_t = m_n;
            m_cause = {s_s, !m_db, !l_s, 1'b0};
          end else if (m_phase == P_HOLD && m_n - m_t == HOLD_C) begin
            m_phase = P_RUN;
          end
        end
        default: m_phase = P_ASSERT;
      endcase
      if (b_s != m_db) begin
        m_run++;
        if (m_run == (1 << DBB)) begin
          m_db = b_s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      exp_q.push_back({m_phase == P_ASSERT, m_phase != P_RUN, m_cause});
    end
  end

  // scoreboard monitor
  always @(negedge clock) begin
    logic [5:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("outputs{mmcm_reset,areset,cause}", {26'd0, mmcm_reset, areset, cause}, {26'd0, e});
    end
  end

  // driver tasks
  task automatic measure_por(input string name);
    int mmcm_edge = 0;
    int k;
    for (k = 1; k <= 200; k++) begin
      @(posedge clock);
      #1;
      if (mmcm_edge == 0 && !mmcm_reset) mmcm_edge = k;
      if (!areset) break;
    end
    check({name, " mmcm_reset fall edge"}, mmcm_edge, MIN_AS);
    check({name, " areset fall edge"}, k, 21);
    check({name, " cause"}, cause, 4'b0001);
  endtask

  task automatic measure_areset(input logic level, input int exp_edges, input string name);
    int k;
    for (k = 1; k <= 300; k++) begin
      @(posedge clock);
      #1;
      if (areset == level) break;
    end
    check(name, k, exp_edges);
  endtask

  task automatic wait_phase(input int p, input int age, input string name);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (m_phase == p && (age < 0 || m_n - m_t == age)) break;
    end
    check({name, " reached"}, k < 1000, 1);
  endtask

  task automatic sw_pulse(input int len);
    @(negedge clock);
    sw_rst_req = 1'b1;
    repeat (len) @(negedge clock);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    int kind, len;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    measure_por("por");

    // short button glitch is filtered
    @(negedge clock);
    btn_n = 1'b0;
    repeat (5) @(negedge clock);
    btn_n = 1'b1;
    repeat (20) @(negedge clock);
    check("glitch areset", areset, 1'b0);
    check("glitch cause", cause, 4'b0001);

    // long press: 2 sync + 8 debounce + 1 edges to areset
    @(negedge clock);
    btn_n = 1'b0;
    measure_areset(1'b1, SYNC + (1 << DBB) + 1, "btn areset rise edge");
    repeat (9) @(negedge clock);
    btn_n = 1'b1;
    measure_areset(1'b0, SYNC + (1 << DBB) + 1 + HOLD_C, "btn release areset fall edge");
    check("btn cause", cause, 4'b0100);

    // lock loss ten cycles into HOLD
    sw_pulse(2);
    wait_phase(P_HOLD, 10, "hold cycle 10");
    pll_locked = 1'b0;
    repeat (3) @(negedge clock);
    pll_locked = 1'b1;
    wait_phase(P_RUN, -1, "run after lock loss");
    check("lock loss cause", cause, 4'b0010);
    check("lock loss areset", areset, 1'b0);

    // simultaneous sw request and lock loss in RUN
    @(negedge clock);
    sw_rst_req = 1'b1;
    pll_locked = 1'b0;
    measure_areset(1'b1, SYNC + 1, "sw+lock areset rise edge");
    check("sw+lock cause", cause, 4'b1010);
    @(negedge clock);
    sw_rst_req = 1'b0;
    pll_locked = 1'b1;
    wait_phase(P_RUN, -1, "run after sw+lock");

    // reset_n pulsed mid-HOLD
    sw_pulse(1);
    wait_phase(P_HOLD, 5, "hold cycle 5");
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check("async reset outputs", {26'd0, mmcm_reset, areset, cause}, {26'd0, RESET_EXP});
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    measure_por("por again");

    // randomized request traffic
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 14);
      @(negedge clock);
      case (kind)
        0: btn_n = 1'b0;
        1: sw_rst_req = 1'b1;
        2: pll_locked = 1'b0;
        default: begin btn_n = 1'b0; pll_locked = 1'b0; end
      endcase
      repeat (len) @(negedge clock);
      btn_n = 1'b1;
      sw_rst_req = 1'b0;
      pll_locked = 1'b1;
      repeat ($urandom_range(0, 40)) @(negedge clock);
    end
    repeat (60) @(negedge clock);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
